// File: rtl/obstacle_scheduler.sv
// Ten-slot obstacle table: scrolls, retires and spawns obstacles once per frame tick
// while in play, then publishes the whole table to the renderer in one cycle.
module obstacle_scheduler #(
   parameter int          N_OBS        = 10,
   parameter int          SCREEN_W     = 640,
   parameter int          OBS_W        = 20,
   parameter int          OBS_H        = 40,
   parameter int          Y_BASE       = 60,
   parameter int          SPEED        = 4,
   parameter int          SPAWN_PERIOD = 60,
   parameter logic [1:0]  GM_PLAY      = 2'b01,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic [1:0]             gamemode,
   input  logic                   game_start,
   output logic [N_OBS-1:0][9:0]  obstacle_x_game_left,
   output logic [N_OBS-1:0][9:0]  obstacle_x_game_right,
   output logic [N_OBS-1:0][8:0]  obstacle_y_game_up,
   output logic [N_OBS-1:0][8:0]  obstacle_y_game_down,
   output logic [N_OBS-1:0]       obstacle_valid,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   spawn_drop
);

   localparam int         IDX_W      = $clog2(N_OBS);
   localparam logic [9:0] SPEED_V    = 10'(SPEED);
   localparam logic [9:0] SPAWN_LAST = 10'(SPAWN_PERIOD - 1);
   localparam logic [9:0] SPAWN_XL   = 10'(SCREEN_W - OBS_W);
   localparam logic [9:0] SPAWN_XR   = 10'(SCREEN_W - 1);
   localparam logic [8:0] Y_BASE_V   = 9'(Y_BASE);
   localparam logic [8:0] OBS_H_M1   = 9'(OBS_H - 1);

   typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, COMMIT} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [9:0]             spawn_cnt;
   logic [15:0]            lfsr;
   logic [N_OBS-1:0][9:0]  sh_xl;
   logic [N_OBS-1:0][9:0]  sh_xr;
   logic [N_OBS-1:0][8:0]  sh_yu;
   logic [N_OBS-1:0][8:0]  sh_yd;
   logic [N_OBS-1:0]       sh_v;

   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic [15:0]            lfsr_next;
   logic [8:0]             spawn_y;

   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign spawn_y   = Y_BASE_V + {1'b0, lfsr[7:0]};
   assign busy      = (state != IDLE);

   // Lowest-index free slot: scan downward so the last hit is the lowest index.
   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N_OBS - 1; i >= 0; i--) begin
         if (!sh_v[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the slot tables are reset because invalid slots must read back as zero.
      if (rst) begin
         state                 <= IDLE;
         idx                   <= '0;
         spawn_cnt             <= '0;
         lfsr                  <= LFSR_SEED;
         sh_xl                 <= '0;
         sh_xr                 <= '0;
         sh_yu                 <= '0;
         sh_yd                 <= '0;
         sh_v                  <= '0;
         obstacle_x_game_left  <= '0;
         obstacle_x_game_right <= '0;
         obstacle_y_game_up    <= '0;
         obstacle_y_game_down  <= '0;
         obstacle_valid        <= '0;
         frame_done            <= 1'b0;
         spawn_drop            <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         frame_done <= 1'b0;
         spawn_drop <= 1'b0;
         if (game_start) begin
            state                 <= IDLE;
            idx                   <= '0;
            spawn_cnt             <= '0;
            lfsr                  <= LFSR_SEED;
            sh_xl                 <= '0;
            sh_xr                 <= '0;
            sh_yu                 <= '0;
            sh_yd                 <= '0;
            sh_v                  <= '0;
            obstacle_x_game_left  <= '0;
            obstacle_x_game_right <= '0;
            obstacle_y_game_up    <= '0;
            obstacle_y_game_down  <= '0;
            obstacle_valid        <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (frame_tick && gamemode == GM_PLAY) begin
                     state <= SCROLL;
                     idx   <= '0;
                  end
               end
               SCROLL: begin
                  if (sh_v[idx]) begin
                     if (sh_xr[idx] < SPEED_V) begin
                        sh_v[idx]  <= 1'b0;
                        sh_xl[idx] <= '0;
                        sh_xr[idx] <= '0;
                        sh_yu[idx] <= '0;
                        sh_yd[idx] <= '0;
                     end else begin
                        sh_xr[idx] <= sh_xr[idx] - SPEED_V;
                        sh_xl[idx] <= (sh_xl[idx] >= SPEED_V) ? sh_xl[idx] - SPEED_V : '0;
                     end
                  end
                  if (idx == IDX_W'(N_OBS - 1)) state <= SPAWN;
                  else                          idx   <= idx + IDX_W'(1);
               end
               SPAWN: begin
                  if (spawn_cnt == SPAWN_LAST) begin
                     spawn_cnt <= '0;
                     if (free_found) begin
                        sh_v[free_idx]  <= 1'b1;
                        sh_xl[free_idx] <= SPAWN_XL;
                        sh_xr[free_idx] <= SPAWN_XR;
                        sh_yu[free_idx] <= spawn_y;
                        sh_yd[free_idx] <= spawn_y + OBS_H_M1;
                        lfsr            <= lfsr_next;
                     end else begin
                        spawn_drop <= 1'b1;
                     end
                  end else begin
                     spawn_cnt <= spawn_cnt + 10'd1;
                  end
                  state <= COMMIT;
               end
               COMMIT: begin
                  obstacle_x_game_left  <= sh_xl;
                  obstacle_x_game_right <= sh_xr;
                  obstacle_y_game_up    <= sh_yu;
                  obstacle_y_game_down  <= sh_yd;
                  obstacle_valid        <= sh_v;
                  frame_done            <= 1'b1;
                  state                 <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized-timing bench for obstacle_scheduler, checked against a per-frame
// behavioural model of the obstacle table (two DUTs: default and SPEED=0/SPAWN_PERIOD=1).
module tb_obstacle_scheduler;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             a_tick, a_gs, b_tick, b_gs;
   logic [1:0]       a_gm, b_gm;
   logic [9:0][9:0]  a_xl, a_xr, b_xl, b_xr;
   logic [9:0][8:0]  a_yu, a_yd, b_yu, b_yd;
   logic [9:0]       a_v, b_v;
   logic             a_busy, a_done, a_drop, b_busy, b_done, b_drop;

   obstacle_scheduler u_a (
      .clk(clk), .rst(rst), .frame_tick(a_tick), .gamemode(a_gm), .game_start(a_gs),
      .obstacle_x_game_left(a_xl), .obstacle_x_game_right(a_xr),
      .obstacle_y_game_up(a_yu), .obstacle_y_game_down(a_yd),
      .obstacle_valid(a_v), .busy(a_busy), .frame_done(a_done), .spawn_drop(a_drop));

   obstacle_scheduler #(.SPEED(0), .SPAWN_PERIOD(1)) u_b (
      .clk(clk), .rst(rst), .frame_tick(b_tick), .gamemode(b_gm), .game_start(b_gs),
      .obstacle_x_game_left(b_xl), .obstacle_x_game_right(b_xr),
      .obstacle_y_game_up(b_yu), .obstacle_y_game_down(b_yd),
      .obstacle_valid(b_v), .busy(b_busy), .frame_done(b_done), .spawn_drop(b_drop));

   int checks   = 0;
   int failures = 0;

   // Observation mux: which DUT the frame task is driving.
   bit              sel_b = 1'b0;
   logic [9:0][9:0] o_xl, o_xr;
   logic [9:0][8:0] o_yu, o_yd;
   logic [9:0]      o_v;
   logic            o_done, o_drop;
   always_comb begin
      o_xl   = sel_b ? b_xl   : a_xl;
      o_xr   = sel_b ? b_xr   : a_xr;
      o_yu   = sel_b ? b_yu   : a_yu;
      o_yd   = sel_b ? b_yd   : a_yd;
      o_v    = sel_b ? b_v    : a_v;
      o_done = sel_b ? b_done : a_done;
      o_drop = sel_b ? b_drop : a_drop;
   end

   // Reference model: table state after each completed frame.
   int m_xl[10], m_xr[10], m_yu[10], m_yd[10];
   bit m_v[10];
   int m_cnt, m_lfsr;
   bit m_drop;

   task automatic model_reset();
      for (int i = 0; i < 10; i++) begin
         m_xl[i] = 0; m_xr[i] = 0; m_yu[i] = 0; m_yd[i] = 0; m_v[i] = 0;
      end
      m_cnt = 0; m_lfsr = 16'hACE1; m_drop = 0;
   endtask

   task automatic model_frame(input int speed, input int period);
      int slot, fb;
      for (int i = 0; i < 10; i++) begin
         if (m_v[i]) begin
            if (m_xr[i] < speed) begin
               m_v[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yu[i] = 0; m_yd[i] = 0;
            end else begin
               m_xr[i] -= speed;
               m_xl[i] = (m_xl[i] >= speed) ? m_xl[i] - speed : 0;
            end
         end
      end
      m_drop = 0;
      if (m_cnt == period - 1) begin
         m_cnt = 0;
         slot  = -1;
         for (int i = 0; i < 10; i++) if (!m_v[i] && slot < 0) slot = i;
         if (slot >= 0) begin
            m_v[slot]  = 1;
            m_xl[slot] = 620;
            m_xr[slot] = 639;
            m_yu[slot] = 60 + (m_lfsr & 255);
            m_yd[slot] = m_yu[slot] + 39;
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
         end else begin
            m_drop = 1;
         end
      end else begin
         m_cnt++;
      end
   endtask

   function automatic logic [9:0][9:0] exp_x(input bit right);
      for (int i = 0; i < 10; i++) exp_x[i] = 10'(right ? m_xr[i] : m_xl[i]);
   endfunction

   function automatic logic [9:0][8:0] exp_y(input bit down);
      for (int i = 0; i < 10; i++) exp_y[i] = 9'(down ? m_yd[i] : m_yu[i]);
   endfunction

   function automatic logic [9:0] exp_v();
      for (int i = 0; i < 10; i++) exp_v[i] = m_v[i];
   endfunction

   // One processed frame: tick, bounded wait for frame_done, compare against model.
   task automatic do_frame(input string tag);
      int  lat   = 0;
      int  drops = 0;
      bit  seen  = 0;
      @(negedge clk);
      if (sel_b) b_tick = 1'b1; else a_tick = 1'b1;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) begin
            a_tick = 1'b0; b_tick = 1'b0;
            if (!sel_b) a_gm = 2'($urandom_range(0, 3));
         end
         if (o_drop) drops++;
         if (o_done) begin seen = 1; lat = c; end
      end
      a_gm = 2'b01;
      if (sel_b) model_frame(0, 1); else model_frame(4, 60);
      checks++;
      if (lat != 13) begin
         failures++;
         $display("FAIL %s frame_done_latency got=%0d exp=13", tag, lat);
      end
      checks++;
      if (drops != int'(m_drop)) begin
         failures++;
         $display("FAIL %s spawn_drop_pulses got=%0d exp=%0d", tag, drops, m_drop);
      end
      checks++;
      if (o_v !== exp_v() || o_xl !== exp_x(0) || o_xr !== exp_x(1) ||
          o_yu !== exp_y(0) || o_yd !== exp_y(1)) begin
         failures++;
         $display("FAIL %s table v=%h/%h xl=%h/%h xr=%h/%h yu=%h/%h yd=%h/%h", tag,
                  o_v, exp_v(), o_xl, exp_x(0), o_xr, exp_x(1), o_yu, exp_y(0), o_yd, exp_y(1));
      end
      repeat ($urandom_range(1, 8)) @(negedge clk);
   endtask

   task automatic run_frames(input int n, input string tag);
      for (int f = 0; f < n; f++) do_frame(tag);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if (a_v !== 0 || a_xl !== 0 || a_xr !== 0 || a_yu !== 0 || a_yd !== 0 ||
          a_busy !== 0 || a_done !== 0 || a_drop !== 0) begin
         failures++;
         $display("FAIL reset_state v=%h busy=%b done=%b drop=%b exp all 0", a_v, a_busy, a_done, a_drop);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_first_spawn();
      @(negedge clk); a_gs = 1'b1;
      @(negedge clk); a_gs = 1'b0;
      model_reset();
      run_frames(59, "first_spawn");
      checks++;
      if (a_v !== 10'h000) begin
         failures++; $display("FAIL frame59_empty v=%h exp=000", a_v);
      end
      do_frame("first_spawn60");
      checks++;
      if (a_v[0] !== 1'b1 || a_xl[0] !== 10'd620 || a_xr[0] !== 10'd639 ||
          a_yu[0] !== 9'd285 || a_yd[0] !== 9'd324) begin
         failures++;
         $display("FAIL slot0_spawn v=%b l=%0d r=%0d u=%0d d=%0d exp 1/620/639/285/324",
                  a_v[0], a_xl[0], a_xr[0], a_yu[0], a_yd[0]);
      end
   endtask

   task automatic test_scroll_retire();
      do_frame("scroll61");
      checks++;
      if (a_xl[0] !== 10'd616 || a_xr[0] !== 10'd635) begin
         failures++; $display("FAIL slot0_scroll l=%0d r=%0d exp 616/635", a_xl[0], a_xr[0]);
      end
      run_frames(158, "scroll");
      checks++;
      if (a_v[0] !== 1'b1 || a_xl[0] !== 10'd0 || a_xr[0] !== 10'd3) begin
         failures++; $display("FAIL slot0_clamp v=%b l=%0d r=%0d exp 1/0/3", a_v[0], a_xl[0], a_xr[0]);
      end
      do_frame("retire");
      checks++;
      if (a_v[0] !== 1'b0 || a_xl[0] !== 0 || a_xr[0] !== 0 || a_yu[0] !== 0 || a_yd[0] !== 0 ||
          a_v[2:1] !== 2'b11) begin
         failures++;
         $display("FAIL slot0_retire v=%h l=%0d r=%0d u=%0d d=%0d exp v=006 coords 0",
                  a_v, a_xl[0], a_xr[0], a_yu[0], a_yd[0]);
      end
   endtask

   task automatic watch_quiet(input string tag);
      int hits = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (a_busy || a_done) hits++;
      end
      checks++;
      if (hits != 0) begin
         failures++; $display("FAIL %s busy_or_done_cycles got=%0d exp=0", tag, hits);
      end
   endtask

   task automatic check_cleared(input string tag);
      checks++;
      if (a_busy !== 0 || a_v !== 0 || a_xl !== 0 || a_xr !== 0 || a_yu !== 0 || a_yd !== 0) begin
         failures++;
         $display("FAIL %s cleared busy=%b v=%h xl=%h yu=%h exp all 0", tag, a_busy, a_v, a_xl, a_yu);
      end
   endtask

   task automatic test_game_start();
      // Abort mid-SCROLL (slot index 5) with a populated table.
      @(negedge clk); a_tick = 1'b1;
      @(negedge clk); a_tick = 1'b0;
      repeat (5) @(negedge clk);
      a_gs = 1'b1;
      @(negedge clk); a_gs = 1'b0;
      watch_quiet("gs_mid_scroll");
      check_cleared("gs_mid_scroll");
      model_reset();
      run_frames(60, "after_gs");
      checks++;
      if (a_yu[0] !== 9'd285) begin
         failures++; $display("FAIL respawn_y got=%0d exp=285", a_yu[0]);
      end
      // game_start and frame_tick together: tick is dropped.
      @(negedge clk); a_tick = 1'b1; a_gs = 1'b1;
      @(negedge clk); a_tick = 1'b0; a_gs = 1'b0;
      watch_quiet("gs_with_tick");
      check_cleared("gs_with_tick");
      model_reset();
      run_frames(60, "repopulate");
   endtask

   task automatic test_not_play();
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         a_gm = (t == 0) ? 2'b10 : 2'($urandom_range(2, 3)) ^ ($urandom_range(0, 1) ? 2'b00 : 2'b10);
         if (a_gm == 2'b01) a_gm = 2'b10;
         a_tick = 1'b1;
         @(negedge clk); a_tick = 1'b0;
         watch_quiet("not_play");
      end
      a_gm = 2'b01;
      checks++;
      if (a_v !== exp_v() || a_xl !== exp_x(0) || a_yu !== exp_y(0)) begin
         failures++; $display("FAIL not_play_frozen v=%h/%h xl=%h/%h", a_v, exp_v(), a_xl, exp_x(0));
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); a_tick = 1'b1;
      @(negedge clk); a_tick = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (a_busy !== 0 || a_v !== 0 || a_xl !== 0 || a_xr !== 0 || a_yu !== 0 || a_yd !== 0) begin
         failures++;
         $display("FAIL async_reset busy=%b v=%h xl=%h yu=%h exp all 0", a_busy, a_v, a_xl, a_yu);
      end
      @(negedge clk); rst = 1'b0;
      model_reset();
      run_frames(59, "post_reset");
      checks++;
      if (a_v !== 10'h000) begin
         failures++; $display("FAIL post_reset_empty v=%h exp=000", a_v);
      end
      do_frame("post_reset60");
      checks++;
      if (a_v !== 10'h001 || a_yu[0] !== 9'd285) begin
         failures++; $display("FAIL post_reset_spawn v=%h u=%0d exp 001/285", a_v, a_yu[0]);
      end
   endtask

   task automatic test_full_table();
      sel_b = 1'b1;
      @(negedge clk); b_gs = 1'b1;
      @(negedge clk); b_gs = 1'b0;
      model_reset();
      run_frames(10, "fill");
      checks++;
      if (b_v !== 10'h3FF) begin
         failures++; $display("FAIL full_table v=%h exp=3ff", b_v);
      end
      do_frame("overflow");
      checks++;
      if (m_drop !== 1'b1 || u_b.lfsr !== 16'(m_lfsr)) begin
         failures++; $display("FAIL overflow_lfsr got=%h exp=%h", u_b.lfsr, 16'(m_lfsr));
      end
      sel_b = 1'b0;
   endtask

   initial begin
      a_tick = 0; a_gs = 0; a_gm = 2'b01;
      b_tick = 0; b_gs = 0; b_gm = 2'b01;
      test_reset();
      test_first_spawn();
      test_scroll_retire();
      test_game_start();
      test_not_play();
      test_async_reset();
      test_full_table();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Owns the 10-slot obstacle table that drives the screen renderer's obstacle_x_game_left/right and obstacle_y_game_up/down inputs.
- On each frame tick during play, it walks the slots to scroll them left, retires slots that leave the screen, and spawns a new obstacle at the right edge. The vertical position of a new obstacle comes from an LFSR.
- Outputs update atomically once per frame, so the renderer never sees a half-updated table.

Parameters:
- N_OBS, 10, number of slots (fixed by the renderer interface)
- SCREEN_W, 640, horizontal pixels
- OBS_W, 20, obstacle width in pixels (x_right = x_left + OBS_W - 1)
- OBS_H, 40, obstacle height in pixels (y_down = y_up + OBS_H - 1)
- Y_BASE, 60, minimum y_up
- SPEED, 4, pixels scrolled per frame (legal range 0..15)
- SPAWN_PERIOD, 60, processed frames between spawn attempts (legal range 1..1023)
- GM_PLAY, 2'b01, gamemode value in which the block advances
- LFSR_SEED, 16'hACE1, LFSR value after reset or game_start

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_tick  in  1  one-cycle pulse at vblank start
- gamemode  in  2  current game mode
- game_start  in  1  one-cycle pulse; clears the table for a new game
- obstacle_x_game_left  out  [9:0][9:0]  per-slot left x
- obstacle_x_game_right  out  [9:0][9:0]  per-slot right x
- obstacle_y_game_up  out  [9:0][8:0]  per-slot top y
- obstacle_y_game_down  out  [9:0][8:0]  per-slot bottom y
- obstacle_valid  out  10  per-slot occupied flag
- busy  out  1  high while not in IDLE
- frame_done  out  1  one-cycle pulse after commit
- spawn_drop  out  1  one-cycle pulse when a spawn finds no free slot

Behaviour:
- Reset (async):
  - All output arrays, shadow slot registers, obstacle_valid, busy, frame_done and spawn_drop go to 0.
  - Spawn counter goes to 0, LFSR goes to LFSR_SEED, FSM goes to IDLE.
- Invalid slots always output all four coordinates as 0.
- FSM states and transitions:
  - IDLE: if frame_tick && gamemode==GM_PLAY, go to SCROLL with idx=0. Otherwise stay; a tick outside play is ignored (table frozen).
  - SCROLL: handles one slot per cycle, idx 0..9, for 10 cycles total.
    - If the slot is valid and x_right < SPEED, the slot retires (valid=0, coordinates cleared).
    - Otherwise x_right -= SPEED, and x_left = (x_left >= SPEED) ? x_left - SPEED : 0 (clamped at 0).
    - Invalid slots are untouched. After idx 9, go to SPAWN.
  - SPAWN: one cycle.
    - If spawn_cnt == SPAWN_PERIOD-1: set spawn_cnt=0. If a free slot exists, fill the lowest-index free slot with x_left=SCREEN_W-OBS_W, x_right=SCREEN_W-1, y_up=Y_BASE+lfsr[7:0], y_down=y_up+OBS_H-1, valid=1, then advance the LFSR one step. If no slot is free, the spawn is dropped, spawn_drop is set for one cycle and the LFSR does not advance.
    - Otherwise spawn_cnt += 1.
    - Go to COMMIT.
  - COMMIT: copy the shadow table to the output registers, set frame_done for one cycle, go to IDLE.
- A newly spawned obstacle is not scrolled in its spawn frame.
- Latency: a tick sampled at edge k makes new outputs visible after edge k+12. frame_done is high during the cycle following that edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left with the feedback entering bit 0.
- Width rules: y_up ≤ 60+255 = 315 and y_down ≤ 354, so both fit in 9 bits. All x values stay within 0..639.
- frame_tick while busy: ignored and not queued.
- game_start has priority in any state. On the next edge it:
  - clears the shadow table, the outputs and obstacle_valid;
  - sets spawn_cnt=0 and LFSR=LFSR_SEED;
  - sets FSM=IDLE and suppresses frame_done.
  - game_start and frame_tick in the same cycle: game_start wins and the tick is dropped.
- A gamemode change mid-frame does not abort the frame; the frame completes. Only acceptance in IDLE checks gamemode.

Test Plan:
1. Assert rst mid-SCROLL with a populated table → all outputs, obstacle_valid and busy read 0 immediately (asynchronously). The next tick in play yields no obstacles until frame 60.
2. gamemode=01, game_start, then 60 ticks spaced 20 cycles apart → after the 60th commit, slot0 valid with left=620, right=639, up=285 (60+0xE1), down=324. frame_done pulses 12 edges after each tick.
3. Continue from scenario 2 with 1 more tick → slot0 left=616, right=635. After 159 scroll frames slot0 shows left=0 (clamped), right=3. Frame 160 retires slot0 (valid=0, all coordinates 0). Slots 1 and 2 were spawned at frames 120 and 180 with LFSR-stepped y_up.
4. gamemode=10 with 5 ticks → outputs unchanged, busy never rises, no frame_done.
5. SPEED=0, SPAWN_PERIOD=1, 11 ticks → after tick 10 obstacle_valid=10'h3FF. Tick 11 raises spawn_drop for one cycle, the table is unchanged and the LFSR is unchanged.
6. game_start coincident with frame_tick, and game_start during SCROLL idx 5 → FSM back in IDLE, table cleared, no frame_done. The next spawn's y_up is again 285.
